// File: rtl/pipe_skid_slice.sv
// Pipeline register slice: valid/ready handshake, main + skid entry, registered in_ready, stall and flush.
// Optional saturating perf counters are enabled by defining PIPE_SKID_SLICE_PERF_CNT_EN.
module pipe_skid_slice #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter bit          ZERO_WHEN_EMPTY = 1'b1,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  bubble_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);

  localparam int unsigned DW = DATA_WIDTH;

  logic          main_v_q, main_v_d;
  logic          skid_v_q, skid_v_d;
  logic          in_ready_q;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic [DW-1:0] empty_data_c;
  logic          in_fire_c;
  logic          out_fire_c;

  assign in_fire_c    = in_valid & in_ready_q;
  assign out_fire_c   = main_v_q & out_ready & ~stall;
  // The main register doubles as out_data, so an emptied slice either zeroes or holds it.
  assign empty_data_c = ZERO_WHEN_EMPTY ? '0 : main_q;

  // Next-state for the two-entry buffer.
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d   = empty_data_c;
    end else if (!main_v_q || out_fire_c) begin
      if (skid_v_q) begin
        main_v_d = 1'b1;
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (in_fire_c) begin
        main_v_d = 1'b1;
        main_d   = in_data;
      end else begin
        main_v_d = 1'b0;
        main_d   = empty_data_c;
      end
    end else if (in_fire_c) begin
      skid_v_d = 1'b1;
      skid_d   = in_data;
    end
  end

  // Buffer state; in_ready is registered from the next skid occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= ~skid_v_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_data  = main_q;

`ifdef PIPE_SKID_SLICE_PERF_CNT_EN
  localparam int unsigned CW = CNT_WIDTH;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (main_v_q && !out_fire_c && (stall_cnt_q != CNT_MAX))
        stall_cnt_q <= stall_cnt_q + CW'(1);
      if (!main_v_q && out_ready && (bubble_cnt_q != CNT_MAX))
        bubble_cnt_q <= bubble_cnt_q + CW'(1);
      if (flush && (flush_cnt_q != CNT_MAX))
        flush_cnt_q <= flush_cnt_q + CW'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_slice.sv
// Directed bench for pipe_skid_slice with a FIFO scoreboard of accepted beats.
module tb_pipe_skid_slice;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
`ifdef PIPE_SKID_SLICE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, flush, stall, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  pipe_skid_slice #(
    .DATA_WIDTH(DW),
    .ZERO_WHEN_EMPTY(1'b1),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .stall(stall),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Score transfers about to happen at the next edge, advance one cycle, check empty-zeroing.
  task automatic tick();
    bit ofire, ifire;
    ofire = rst_n && out_valid && out_ready && !stall;
    ifire = rst_n && in_valid && in_ready;
    if (ofire) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $error("FAIL spurious_beat: observed %0h expected no beat", out_data);
      end else begin
        check("beat_data", 64'(out_data), 64'(sb.pop_front()));
      end
    end
    if (ifire) sb.push_back(in_data);
    if (flush || !rst_n) sb.delete();
    @(posedge clk);
    #1;
    if (!out_valid) check("zero_when_empty", 64'(out_data), 64'(0));
  endtask

  task automatic check_cnts(input string tag, input int s, input int b, input int f);
    check({tag, "_stall_cnt"},  64'(stall_cnt),  PERF ? 64'(s) : 64'(0));
    check({tag, "_bubble_cnt"}, 64'(bubble_cnt), PERF ? 64'(b) : 64'(0));
    check({tag, "_flush_cnt"},  64'(flush_cnt),  PERF ? 64'(f) : 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset for two cycles
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data",  64'(out_data),  64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check_cnts("rst", 0, 0, 0);

    // Stream 0x11,0x22,0x33 at full rate
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    in_data = 32'h11; tick();
    check("lat_valid", 64'(out_valid), 64'(1));
    check("lat_data",  64'(out_data),  64'(32'h11));
    check("stream_rdy0", 64'(in_ready), 64'(1));
    in_data = 32'h22; tick();
    check("stream_data1", 64'(out_data), 64'(32'h22));
    check("stream_rdy1", 64'(in_ready), 64'(1));
    in_data = 32'h33; tick();
    check("stream_data2", 64'(out_data), 64'(32'h33));
    check("stream_rdy2", 64'(in_ready), 64'(1));
    in_valid = 1'b0; tick();
    check("stream_drained", 64'(out_valid), 64'(0));

    // Backpressure fill then release
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hA1; tick();
    check("bp_rdy_after1", 64'(in_ready), 64'(1));
    in_data = 32'hA2; tick();
    check("bp_rdy_full", 64'(in_ready), 64'(0));
    in_data = 32'hA3; tick();
    check("bp_rdy_held", 64'(in_ready), 64'(0));
    check("bp_main_held", 64'(out_data), 64'(32'hA1));
    out_ready = 1'b1; tick();
    check("bp_skid_to_main", 64'(out_data), 64'(32'hA2));
    check("bp_rdy_back", 64'(in_ready), 64'(1));
    tick();
    check("bp_a3", 64'(out_data), 64'(32'hA3));
    in_valid = 1'b0; tick();
    check("bp_drained", 64'(out_valid), 64'(0));

    // Stall with main=0x55 after a fresh reset
    rst_n = 1'b0; tick();
    rst_n = 1'b1; in_valid = 1'b1; in_data = 32'h55; tick();
    in_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_data",  64'(out_data),  64'(32'h55));
    end
    check("stall_stall_cnt", 64'(stall_cnt), PERF ? 64'(3) : 64'(0));
    stall = 1'b0; tick();
    check("stall_released", 64'(out_valid), 64'(0));
    tick();
    check("stall_no_dup", 64'(out_valid), 64'(0));

    // Flush while full, with 0x03 offered upstream
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h01; tick();
    in_data = 32'h02; tick();
    check("fl_full", 64'(in_ready), 64'(0));
    in_data = 32'h03; flush = 1'b1; tick();
    check("fl_valid", 64'(out_valid), 64'(0));
    check("fl_data",  64'(out_data),  64'(0));
    check("fl_rdy",   64'(in_ready),  64'(1));
    check("fl_flush_cnt", 64'(flush_cnt), PERF ? 64'(1) : 64'(0));
    // Flush with an in_fire into an empty slice drops the beat
    out_ready = 1'b1; in_data = 32'h77; tick();
    check("fl_drop_valid", 64'(out_valid), 64'(0));
    check("fl_flush_cnt2", 64'(flush_cnt), PERF ? 64'(2) : 64'(0));
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("fl_nothing_out", 64'(out_valid), 64'(0));

    // Reset and flush together with a buffered beat
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h88; tick();
    check("col_buffered", 64'(out_data), 64'(32'h88));
    rst_n = 1'b0; flush = 1'b1; in_valid = 1'b0; stall = 1'b1; tick();
    check("col_valid", 64'(out_valid), 64'(0));
    check("col_data",  64'(out_data),  64'(0));
    check("col_rdy",   64'(in_ready),  64'(1));
    check_cnts("col", 0, 0, 0);

    // Bubble counter saturation
    rst_n = 1'b1; flush = 1'b0; stall = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check_cnts("sat15", 0, 15, 0);
    for (int i = 0; i < 5; i++) tick();
    check_cnts("sat20", 0, 15, 0);

    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
